branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencer for control-flow resolution in the EX stage of the pipelined core. It evaluates the branch condition from the EX-stage flags when a branch is presented, then drives a one-shot PC redirect and a counted flush of the younger IF/ID stages. It also maintains saturating branch statistics. It sits between the ALU flag outputs and the fetch/decode pipeline registers, and it honours the global pipeline stall.

## Interface
- `FLUSH_CYCLES`, default 2: number of non-stalled cycles for which `flush_if`/`flush_id` are asserted after a taken branch; legal range 1–15.
- `PC_W`, default 16: PC width.

Ports:
- `clk`  in  1  — single clock, rising-edge.
- `rst`  in  1  — synchronous, active-high reset.
- `stall`  in  1  — global pipeline stall; when 1 the block neither evaluates nor advances.
- `br_valid`  in  1  — a control-flow instruction occupies EX this cycle.
- `br_op`  in  4  — condition code using the `BEQZ`/`BNEZ`/`BLTZ`/`BGEZ`/`JUMP` encodings from `opcodes.v`.
- `flags`  in  4  — {SF, ZF, OF, CF}, bit 3 down to bit 0, from the EX ALU.
- `br_target`  in  PC_W  — computed target address.
- `redirect`  out  1  — PC redirect request to fetch.
- `redirect_pc`  out  PC_W  — new PC; valid while `redirect`=1.
- `flush_if`, `flush_id`  out  1 each  — squash IF/ID pipeline registers.
- `busy`  out  1  — FSM not in IDLE.
- `taken_cnt`  out  8  — saturating count of taken branches.
- `resolved_cnt`  out  8  — saturating count of all recognised branches resolved.

## Operation
Condition evaluation (combinational, internal):
- `BEQZ` is taken when ZF=1.
- `BNEZ` is taken when ZF=0.
- `BLTZ` is taken when SF=1.
- `BGEZ` is taken when SF=0.
- `JUMP` is always taken.
- Any other `br_op` is unrecognised: not taken, not counted.

FSM states:
- **IDLE**
  - On a cycle with `br_valid`=1, `stall`=0 and a recognised `br_op`:
    - `resolved_cnt` increments.
    - If taken: `taken_cnt` increments, `redirect_pc` ← `br_target`, flush counter ← `FLUSH_CYCLES`, next state is REDIR.
  - Not taken: remain in IDLE.
- **REDIR**
  - `redirect`=1 and flush outputs=1.
  - If `stall`=0: counter decrements. Next state is FLUSH, or IDLE if the counter reaches 0.
  - If `stall`=1: hold the state, the counter and `redirect`.
- **FLUSH**
  - Flush outputs=1 and `redirect`=0.
  - The counter decrements on each cycle with `stall`=0; return to IDLE when it reaches 0.
  - `br_valid` is ignored, because that instruction is being squashed.

Counters:
- Both counters saturate at 255 and never wrap.
- Both counters hold while `stall`=1.

Outputs:
- All outputs are registered, i.e. decoded from state and registers, with no combinational path from inputs.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - state IDLE, flush counter 0.
  - `redirect`=0, `redirect_pc`=0.
  - `flush_if`=0, `flush_id`=0.
  - `busy`=0.
  - `taken_cnt`=0, `resolved_cnt`=0.
- Redirect latency is one cycle. If a taken branch is sampled at edge *t*, `redirect`, `redirect_pc`, `flush_*` and `busy` are high from *t* to *t+1*.
- Redirect handshake: `redirect` stays high until the first edge with `stall`=0, so fetch sees it for exactly one non-stalled cycle.
- Flush duration: exactly `FLUSH_CYCLES` non-stalled cycles. Stalled cycles extend the assertion but do not count toward it.
- With `FLUSH_CYCLES`=1, REDIR returns directly to IDLE with no FLUSH state visited.
- Back-to-back branches: a branch presented on the edge that returns the FSM to IDLE is not evaluated. The earliest evaluation is on the first edge where the state is already IDLE.
- `rst` asserted in any state, including mid-flush or while stalled:
  - All outputs take their reset values after that edge.
  - `rst` has priority over `stall`.
- `stall`=1 together with `br_valid`=1 in IDLE: no evaluation and no count. The branch is evaluated once `stall` falls.

## Test plan
- **Reset then not-taken branch.** Apply `rst`, then present `br_valid`=1, `br_op`=`BEQZ`, flags=4'b0000.
  - Required: `redirect` stays 0, `resolved_cnt`=1, `taken_cnt`=0.
- **Taken branch.** Present `BNEZ`, flags=4'b0000, `br_target`=16'h0040.
  - Next cycle: `redirect`=1 and `redirect_pc`=16'h0040 for exactly 1 cycle.
  - `flush_if`/`flush_id` high for 2 cycles, then `busy`=0.
- **Stall during REDIR.** `JUMP` taken, then `stall`=1 for 3 cycles starting at *t+1*.
  - Required: `redirect` high for 4 cycles and flush high for 5 cycles in total.
  - `br_valid` asserted during FLUSH is ignored, and `resolved_cnt` increments only once.
- **BLTZ/BGEZ coverage and unrecognised op.**
  - `BLTZ` with flags=4'b1000 → taken.
  - `BGEZ` with flags=4'b1000 → not taken.
  - `br_op`=`SEQ` → no redirect and no count change.
- **Counter saturation.** Issue 260 taken `JUMP`s, each spaced past the flush window.
  - Required: `taken_cnt`=`resolved_cnt`=255 after the 255th, and they remain 255.
- **Reset mid-operation.** Assert `rst` in FLUSH with the counter at 1 and `stall`=1.
  - Next cycle: all outputs are 0 and state is IDLE.
  - A following taken branch behaves exactly as in the "Taken branch" scenario.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: evaluates the condition, issues a one-shot PC redirect,
// then holds IF/ID flush for a counted number of non-stalled cycles.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [3:0]      br_op,
    input  logic [3:0]      flags,
    input  logic [PC_W-1:0] br_target,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush_if,
    output logic            flush_id,
    output logic            busy,
    output logic [7:0]      taken_cnt,
    output logic [7:0]      resolved_cnt
);

    // Condition codes shared with the decoder's opcode map
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_BNEZ = 4'h9;
    localparam logic [3:0] OP_BLTZ = 4'hA;
    localparam logic [3:0] OP_BGEZ = 4'hB;
    localparam logic [3:0] OP_JUMP = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT      state;
    logic [3:0] flushCnt;
    logic [3:0] nextCnt;
    logic       recognised;
    logic       taken;
    logic       signFlag;
    logic       zeroFlag;
    logic       unusedFlags;

    assign signFlag    = flags[3];
    assign zeroFlag    = flags[2];
    assign unusedFlags = ^flags[1:0];
    assign nextCnt     = flushCnt - 4'd1;

    always_comb begin
        recognised = 1'b1;
        taken      = 1'b0;
        unique case (br_op)
            OP_BEQZ: taken = zeroFlag;
            OP_BNEZ: taken = ~zeroFlag;
            OP_BLTZ: taken = signFlag;
            OP_BGEZ: taken = ~signFlag;
            OP_JUMP: taken = 1'b1;
            default: recognised = 1'b0;
        endcase
    end

    // Outputs are registered alongside the state so nothing downstream sees an input path
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            flushCnt     <= 4'd0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
            flush_if     <= 1'b0;
            flush_id     <= 1'b0;
            busy         <= 1'b0;
            taken_cnt    <= 8'd0;
            resolved_cnt <= 8'd0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (br_valid && recognised) begin
                        if (resolved_cnt != 8'hFF) resolved_cnt <= resolved_cnt + 8'd1;
                        if (taken) begin
                            if (taken_cnt != 8'hFF) taken_cnt <= taken_cnt + 8'd1;
                            redirect_pc <= br_target;
                            flushCnt    <= 4'(FLUSH_CYCLES);
                            state       <= REDIR;
                            redirect    <= 1'b1;
                            flush_if    <= 1'b1;
                            flush_id    <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                REDIR, FLUSH: begin
                    // The redirect only ever lasts one non-stalled cycle; the flush may run on
                    flushCnt <= nextCnt;
                    redirect <= 1'b0;
                    if (nextCnt == 4'd0) begin
                        state    <= IDLE;
                        flush_if <= 1'b0;
                        flush_id <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        state <= FLUSH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    flushCnt <= 4'd0;
                    redirect <= 1'b0;
                    flush_if <= 1'b0;
                    flush_id <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: hand-computed expectations per cycle,
// sampled 1 time unit after each rising edge.
module tb_branch_redirect_ctrl;

    localparam logic [3:0] OP_SEQ  = 4'h4;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_BNEZ = 4'h9;
    localparam logic [3:0] OP_BLTZ = 4'hA;
    localparam logic [3:0] OP_BGEZ = 4'hB;
    localparam logic [3:0] OP_JUMP = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [3:0]  br_op;
    logic [3:0]  flags;
    logic [15:0] br_target;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        busy;
    logic [7:0]  taken_cnt;
    logic [7:0]  resolved_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    branch_redirect_ctrl #(.FLUSH_CYCLES(2), .PC_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .br_valid(br_valid),
        .br_op(br_op),
        .flags(flags),
        .br_target(br_target),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .flush_if(flush_if),
        .flush_id(flush_id),
        .busy(busy),
        .taken_cnt(taken_cnt),
        .resolved_cnt(resolved_cnt)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [3:0] f,
                                 input logic [15:0] tgt, input logic s);
        br_valid  = v;
        br_op     = op;
        flags     = f;
        br_target = tgt;
        stall     = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " redirect"}, 32'(redirect), 32'd0);
        checkOutput({tag, " flush_if"}, 32'(flush_if), 32'd0);
        checkOutput({tag, " flush_id"}, 32'(flush_id), 32'd0);
        checkOutput({tag, " busy"},     32'(busy),     32'd0);
    endtask

    // Fresh IDLE state expected; a BNEZ with ZF=0 to 0x0040 must redirect once and flush twice
    task automatic takenBranchScenario(input string tag, input logic [7:0] expRes, input logic [7:0] expTak);
        applyStimulus(1'b1, OP_BNEZ, 4'b0000, 16'h0040, 1'b0);
        step();
        applyStimulus(1'b0, OP_BNEZ, 4'b0000, 16'h0000, 1'b0);
        checkOutput({tag, " redirect t"},    32'(redirect),     32'd1);
        checkOutput({tag, " redirect_pc"},   32'(redirect_pc),  32'h0040);
        checkOutput({tag, " flush_if t"},    32'(flush_if),     32'd1);
        checkOutput({tag, " flush_id t"},    32'(flush_id),     32'd1);
        checkOutput({tag, " busy t"},        32'(busy),         32'd1);
        checkOutput({tag, " resolved_cnt"},  32'(resolved_cnt), 32'(expRes));
        checkOutput({tag, " taken_cnt"},     32'(taken_cnt),    32'(expTak));
        step();
        checkOutput({tag, " redirect t+1"},  32'(redirect),     32'd0);
        checkOutput({tag, " flush_if t+1"},  32'(flush_if),     32'd1);
        checkOutput({tag, " flush_id t+1"},  32'(flush_id),     32'd1);
        checkOutput({tag, " busy t+1"},      32'(busy),         32'd1);
        step();
        checkIdleOutputs({tag, " t+2"});
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 4'h0, 4'h0, 16'h0000, 1'b0);
        step();
        step();
        checkIdleOutputs("reset");
        checkOutput("reset redirect_pc",  32'(redirect_pc),  32'd0);
        checkOutput("reset taken_cnt",    32'(taken_cnt),    32'd0);
        checkOutput("reset resolved_cnt", 32'(resolved_cnt), 32'd0);
        rst = 1'b0;

        // BEQZ with ZF=0: resolved but not taken
        applyStimulus(1'b1, OP_BEQZ, 4'b0000, 16'h1234, 1'b0);
        step();
        applyStimulus(1'b0, OP_BEQZ, 4'b0000, 16'h0000, 1'b0);
        checkIdleOutputs("beqz nt");
        checkOutput("beqz nt resolved", 32'(resolved_cnt), 32'd1);
        checkOutput("beqz nt taken",    32'(taken_cnt),    32'd0);

        takenBranchScenario("bnez", 8'd2, 8'd1);

        // JUMP, then 3 stalled edges in REDIR; br_valid during REDIR/FLUSH must be ignored
        applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'h0080, 1'b0);
        step();
        applyStimulus(1'b0, OP_JUMP, 4'b0000, 16'h0000, 1'b1);
        checkOutput("stall redirect t",   32'(redirect),    32'd1);
        checkOutput("stall redirect_pc",  32'(redirect_pc), 32'h0080);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'h0099, 1'b1);
            step();
            checkOutput("stall redirect held", 32'(redirect), 32'd1);
            checkOutput("stall flush held",    32'(flush_if), 32'd1);
            checkOutput("stall busy held",     32'(busy),     32'd1);
        end
        applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'h0099, 1'b0);
        step();
        checkOutput("stall redirect drop", 32'(redirect),    32'd0);
        checkOutput("stall flush on",      32'(flush_id),    32'd1);
        checkOutput("stall pc held",       32'(redirect_pc), 32'h0080);
        step();
        applyStimulus(1'b0, OP_JUMP, 4'b0000, 16'h0000, 1'b0);
        checkIdleOutputs("stall end");
        checkOutput("stall resolved once", 32'(resolved_cnt), 32'd3);
        checkOutput("stall taken once",    32'(taken_cnt),    32'd2);
        step();
        checkOutput("stall no late eval", 32'(resolved_cnt), 32'd3);
        checkOutput("stall still idle",   32'(busy),         32'd0);

        // BLTZ with SF=1 taken
        applyStimulus(1'b1, OP_BLTZ, 4'b1000, 16'h0100, 1'b0);
        step();
        applyStimulus(1'b0, OP_BLTZ, 4'b0000, 16'h0000, 1'b0);
        checkOutput("bltz redirect",    32'(redirect),     32'd1);
        checkOutput("bltz redirect_pc", 32'(redirect_pc),  32'h0100);
        checkOutput("bltz taken",       32'(taken_cnt),    32'd3);
        step();
        step();
        checkIdleOutputs("bltz done");

        // BGEZ with SF=1 not taken
        applyStimulus(1'b1, OP_BGEZ, 4'b1000, 16'h0200, 1'b0);
        step();
        checkIdleOutputs("bgez nt");
        checkOutput("bgez resolved", 32'(resolved_cnt), 32'd5);
        checkOutput("bgez taken",    32'(taken_cnt),    32'd3);

        // BEQZ with ZF=1 taken, BNEZ with ZF=1 not taken
        applyStimulus(1'b1, OP_BEQZ, 4'b0100, 16'h0300, 1'b0);
        step();
        applyStimulus(1'b0, OP_BEQZ, 4'b0000, 16'h0000, 1'b0);
        checkOutput("beqz t redirect", 32'(redirect),    32'd1);
        checkOutput("beqz t pc",       32'(redirect_pc), 32'h0300);
        step();
        step();
        applyStimulus(1'b1, OP_BNEZ, 4'b0100, 16'h0400, 1'b0);
        step();
        checkIdleOutputs("bnez nt");
        checkOutput("bnez nt resolved", 32'(resolved_cnt), 32'd7);
        checkOutput("bnez nt taken",    32'(taken_cnt),    32'd4);

        // Unrecognised op leaves everything untouched
        applyStimulus(1'b1, OP_SEQ, 4'b0100, 16'h0500, 1'b0);
        step();
        checkIdleOutputs("seq");
        checkOutput("seq resolved", 32'(resolved_cnt), 32'd7);
        checkOutput("seq taken",    32'(taken_cnt),    32'd4);

        // Stall in IDLE defers evaluation until stall falls
        applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'h0600, 1'b1);
        step();
        checkIdleOutputs("idle stall");
        checkOutput("idle stall resolved", 32'(resolved_cnt), 32'd7);
        applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'h0600, 1'b0);
        step();
        applyStimulus(1'b0, OP_JUMP, 4'b0000, 16'h0000, 1'b0);
        checkOutput("idle unstall redirect", 32'(redirect),     32'd1);
        checkOutput("idle unstall resolved", 32'(resolved_cnt), 32'd8);
        step();
        step();

        // Saturation from a clean reset: 260 spaced JUMPs
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'(i), 1'b0);
            step();
            applyStimulus(1'b0, OP_JUMP, 4'b0000, 16'h0000, 1'b0);
            checkOutput("sat taken",    32'(taken_cnt),    (i < 255) ? 32'(i + 1) : 32'd255);
            checkOutput("sat resolved", 32'(resolved_cnt), (i < 255) ? 32'(i + 1) : 32'd255);
            step();
            step();
        end
        checkOutput("sat final taken",    32'(taken_cnt),    32'd255);
        checkOutput("sat final resolved", 32'(resolved_cnt), 32'd255);

        // Reset in FLUSH with counter at 1 while stalled
        applyStimulus(1'b1, OP_JUMP, 4'b0000, 16'h0777, 1'b0);
        step();
        applyStimulus(1'b0, OP_JUMP, 4'b0000, 16'h0000, 1'b0);
        step();
        checkOutput("midrst in flush", 32'(flush_if), 32'd1);
        stall = 1'b1;
        rst   = 1'b1;
        step();
        checkIdleOutputs("midrst");
        checkOutput("midrst redirect_pc",  32'(redirect_pc),  32'd0);
        checkOutput("midrst taken_cnt",    32'(taken_cnt),    32'd0);
        checkOutput("midrst resolved_cnt", 32'(resolved_cnt), 32'd0);
        rst   = 1'b0;
        stall = 1'b0;
        takenBranchScenario("post rst", 8'd1, 8'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
